// File: rtl/simple_cpu_pkg.sv
// Shared Simple CPU definitions: ALU op codes, instruction field positions and
// the sequencer FSM state type.
package simple_cpu_pkg;

  localparam logic [2:0] OpPass = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpXor  = 3'b011;
  localparam logic [2:0] OpOr   = 3'b100;
  localparam logic [2:0] OpAnd  = 3'b101;
  localparam logic [2:0] OpLdi  = 3'b111;

  localparam int unsigned OpMsb  = 15;
  localparam int unsigned OpLsb  = 13;
  localparam int unsigned RdMsb  = 12;
  localparam int unsigned RdLsb  = 10;
  localparam int unsigned RaMsb  = 9;
  localparam int unsigned RaLsb  = 7;
  localparam int unsigned RbMsb  = 6;
  localparam int unsigned RbLsb  = 4;
  localparam int unsigned ImmMsb = 7;
  localparam int unsigned ImmLsb = 0;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWrite
  } seq_state_e;

  // Op codes with no ALU function behind them.
  function automatic logic op_is_illegal(logic [2:0] op);
    return (op == 3'b001) || (op == 3'b110);
  endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// General-purpose register file: two async read ports, one debug read port,
// one synchronous write port, async clear on reset.
module reg_file_8x16 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int unsigned NumRegs = 1 << REG_AW;

  logic [DATA_W-1:0] regs_q [NumRegs];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs_q[raddr_a];
  assign rdata_b  = regs_q[raddr_b];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state control unit that feeds the external ALU from the register file
// and writes the captured result back: IDLE -> READ -> EXEC -> WRITE.
module alu_sequencer
  import simple_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op_select,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result_out,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  seq_state_e        state_q, state_d;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, result_q;
  logic [2:0]        alu_op_q;

  logic [2:0]        op;
  logic [REG_AW-1:0] rd, ra, rb;
  logic [7:0]        imm;
  logic              is_ldi, illegal;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              reg_we;

  assign op      = instr_q[OpMsb:OpLsb];
  assign rd      = instr_q[RdMsb:RdLsb];
  assign ra      = instr_q[RaMsb:RaLsb];
  assign rb      = instr_q[RbMsb:RbLsb];
  assign imm     = instr_q[ImmMsb:ImmLsb];
  assign is_ldi  = (op == OpLdi);
  assign illegal = op_is_illegal(op);

  reg_file_8x16 #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (ra),
    .rdata_a (rdata_a),
    .raddr_b (rb),
    .rdata_b (rdata_b),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .we      (reg_we),
    .waddr   (rd),
    .wdata   (result_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      instr_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OpPass;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && instr_valid) begin
        instr_q <= instr;
      end
      if (state_q == StRead) begin
        // LDI rides through the ALU as PASS of the zero-extended immediate.
        alu_a_q  <= is_ldi ? '0 : rdata_a;
        alu_b_q  <= is_ldi ? {{(DATA_W - 8){1'b0}}, imm} : rdata_b;
        alu_op_q <= (is_ldi || illegal) ? OpPass : op;
      end
      if (state_q == StExec) begin
        result_q <= alu_result;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    reg_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = StRead;
      end
      StRead:  state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: begin
        done    = 1'b1;
        err     = illegal;
        reg_we  = ~illegal;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op_select = alu_op_q;
  assign result_out    = result_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the 16-bit ALU.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_a, alu_b, alu_result, result_out, dbg_data;
  logic [2:0]  alu_op_select, dbg_addr;
  logic        done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_op_select)
      3'b000:  alu_result = alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = alu_a ^ alu_b;
      3'b100:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = alu_a & alu_b;
      default: alu_result = 16'hDEAD;
    endcase
  end

  alu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op_select(alu_op_select),
    .alu_result   (alu_result),
    .done         (done),
    .err          (err),
    .result_out   (result_out),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 4'h0};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {3'b111, rd, 2'b00, imm};
  endfunction

  task automatic check_reg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Issue one instruction and follow it through READ/EXEC/WRITE back to IDLE.
  task automatic run(input string tag, input logic [15:0] ins, input logic [2:0] exp_sel,
                     input logic [15:0] exp_b, input logic [15:0] exp_res,
                     input logic exp_err);
    int n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_ready"}, instr_ready, 1);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);  // E0: accept
    #1;
    instr_valid = 1'b0;
    check({tag, "_busy"}, instr_ready, 0);
    @(posedge clk);  // E1: operands latched, now EXEC
    #1;
    check({tag, "_exec_done"}, done, 0);
    check({tag, "_sel"}, alu_op_select, exp_sel);
    if (!exp_err) check({tag, "_alu_b"}, alu_b, exp_b);
    @(posedge clk);  // E2: result captured, now WRITE
    #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, exp_err);
    if (!exp_err) check({tag, "_result"}, result_out, exp_res);
    @(posedge clk);  // E3: writeback, back to IDLE
    #1;
    check({tag, "_done_low"}, done, 0);
  endtask

  localparam logic [15:0] Doubles [8] = '{16'h01FE, 16'h03FC, 16'h07F8, 16'h0FF0,
                                          16'h1FE0, 16'h3FC0, 16'h7F80, 16'hFF00};

  initial begin
    int acc, dn, consec;
    logic prev_done;
    reset       = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    dbg_addr    = '0;
    #2;
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_sel", alu_op_select, 0);
    check("rst_result", result_out, 0);
    #10;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 16'h0000);

    run("ldi_r1", ldi(3'd1, 8'h34), 3'b000, 16'h0034, 16'h0034, 1'b0);
    check_reg("r1_34", 3'd1, 16'h0034);
    run("ldi_r2", ldi(3'd2, 8'hFF), 3'b000, 16'h00FF, 16'h00FF, 1'b0);
    check_reg("r2_ff", 3'd2, 16'h00FF);
    run("add_r3", enc(3'b010, 3'd3, 3'd1, 3'd2), 3'b010, 16'h00FF, 16'h0133, 1'b0);
    check_reg("r3", 3'd3, 16'h0133);
    run("xor_r4", enc(3'b011, 3'd4, 3'd2, 3'd2), 3'b011, 16'h00FF, 16'h0000, 1'b0);
    check_reg("r4", 3'd4, 16'h0000);
    run("or_r5", enc(3'b100, 3'd5, 3'd1, 3'd2), 3'b100, 16'h00FF, 16'h00FF, 1'b0);
    check_reg("r5", 3'd5, 16'h00FF);
    run("and_r6", enc(3'b101, 3'd6, 3'd1, 3'd2), 3'b101, 16'h00FF, 16'h0034, 1'b0);
    check_reg("r6", 3'd6, 16'h0034);
    run("pass_r7", enc(3'b000, 3'd7, 3'd0, 3'd1), 3'b000, 16'h0034, 16'h0034, 1'b0);
    check_reg("r7", 3'd7, 16'h0034);

    // Build 0xFFFF: double R2 (0x00FF) eight times, then OR with R5 (0x00FF).
    for (int i = 0; i < 8; i++) begin
      run("dbl_r2", enc(3'b010, 3'd2, 3'd2, 3'd2), 3'b010,
          (i == 0) ? 16'h00FF : Doubles[i-1], Doubles[i], 1'b0);
    end
    check_reg("r2_ff00", 3'd2, 16'hFF00);
    run("or_r1", enc(3'b100, 3'd1, 3'd2, 3'd5), 3'b100, 16'h00FF, 16'hFFFF, 1'b0);
    check_reg("r1_ffff", 3'd1, 16'hFFFF);
    run("add_wrap", enc(3'b010, 3'd1, 3'd1, 3'd1), 3'b010, 16'hFFFF, 16'hFFFE, 1'b0);
    check_reg("r1_fffe", 3'd1, 16'hFFFE);

    run("ill_001", enc(3'b001, 3'd1, 3'd2, 3'd3), 3'b000, 16'h0000, 16'h0000, 1'b1);
    check_reg("ill_r1_kept", 3'd1, 16'hFFFE);
    run("ill_110", enc(3'b110, 3'd3, 3'd1, 3'd1), 3'b000, 16'h0000, 16'h0000, 1'b1);
    check_reg("ill_r3_kept", 3'd3, 16'h0133);

    // Throughput: valid held high, one accept every 4 cycles, single-cycle done.
    instr       = ldi(3'd1, 8'h01);
    instr_valid = 1'b1;
    acc         = 0;
    dn          = 0;
    consec      = 0;
    prev_done   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) acc++;
      if (done) dn++;
      if (done && prev_done) consec++;
      prev_done = done;
      @(posedge clk);
    end
    #1;
    instr_valid = 1'b0;
    check("tput_accepts", acc, 3);
    check("tput_dones", dn, 3);
    check("tput_consec_done", consec, 0);
    check_reg("tput_r1", 3'd1, 16'h0001);

    // Reset during EXEC of ADD R3 abandons the instruction.
    @(posedge clk);
    #1;
    instr       = enc(3'b010, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_done", done, 0);
    check("midrst_ready", instr_ready, 1);
    check("midrst_alu_a", alu_a, 0);
    @(negedge clk);
    reset = 1'b0;
    dn    = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midrst_no_done", dn, 0);
    check_reg("midrst_r3", 3'd3, 16'h0000);
    check_reg("midrst_r2", 3'd2, 16'h0000);
    check("midrst_idle", instr_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
